// File: rtl/alu_issue_stage.sv
// alu_issue_stage: LA32R ALU decode plus single-entry issue register.
// Ports: clk/rst, in_valid/in_ready/inst/pc, rf_raddr*/rf_rdata*,
//        flush, out_valid/out_ready, alu_op/alu_src0/alu_src1,
//        rd/rf_we/pc_out/illegal, issue_cnt.

package alu_issue_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SLT  = 5'b00100;
   localparam logic [4:0] OP_SLTU = 5'b00101;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_XOR  = 5'b01011;
   localparam logic [4:0] OP_SLL  = 5'b01110;
   localparam logic [4:0] OP_SRL  = 5'b01111;
   localparam logic [4:0] OP_SRA  = 5'b10000;
   localparam logic [4:0] OP_SRC1 = 5'b10010;

   typedef struct packed {
      logic [4:0]  alu_op;
      logic [31:0] src0;
      logic [31:0] src1;
      logic [4:0]  rd;
      logic        rf_we;
      logic [31:0] pc;
      logic        illegal;
   } iss_t;

endpackage

module alu_issue_stage
   import alu_issue_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   output logic [4:0]  rf_raddr1,
   output logic [4:0]  rf_raddr2,
   input  logic [31:0] rf_rdata1,
   input  logic [31:0] rf_rdata2,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  alu_op,
   output logic [31:0] alu_src0,
   output logic [31:0] alu_src1,
   output logic [4:0]  rd,
   output logic        rf_we,
   output logic [31:0] pc_out,
   output logic        illegal,
   output logic [31:0] issue_cnt
);

   logic [16:0] op17;
   logic [9:0]  op10;
   logic [6:0]  op7;

   logic        is_3r;
   logic        is_shi;
   logic        is_ri;
   logic        is_lu;
   logic        is_pca;
   logic [4:0]  sh_op;
   logic [4:0]  ri_op;
   logic        ri_sext;
   logic [31:0] imm12;
   logic [31:0] imm20;

   iss_t        dec;
   iss_t        q;
   logic        vld;
   logic [31:0] cnt;

   logic        accept;
   logic        fire;

   assign op17 = inst[31:15];
   assign op10 = inst[31:22];
   assign op7  = inst[31:25];

   assign rf_raddr1 = inst[9:5];
   assign rf_raddr2 = inst[14:10];

   // Opcode-class recognition; the classes occupy
   // disjoint encoding ranges, so at most one fires.
   always_comb begin
      is_3r   = 1'b0;
      is_shi  = 1'b0;
      is_ri   = 1'b0;
      sh_op   = OP_SLL;
      ri_op   = OP_ADD;
      ri_sext = 1'b0;
      case (op17)
         17'h00020, 17'h00022,
         17'h00024, 17'h00025,
         17'h00029, 17'h0002A,
         17'h0002B, 17'h0002E,
         17'h0002F, 17'h00030: is_3r = 1'b1;
         17'h00081: begin
            is_shi = 1'b1;
            sh_op  = OP_SLL;
         end
         17'h00089: begin
            is_shi = 1'b1;
            sh_op  = OP_SRL;
         end
         17'h00091: begin
            is_shi = 1'b1;
            sh_op  = OP_SRA;
         end
         default: ;
      endcase
      case (op10)
         10'h008: begin
            is_ri   = 1'b1;
            ri_op   = OP_SLT;
            ri_sext = 1'b1;
         end
         10'h009: begin
            is_ri   = 1'b1;
            ri_op   = OP_SLTU;
            ri_sext = 1'b1;
         end
         10'h00A: begin
            is_ri   = 1'b1;
            ri_op   = OP_ADD;
            ri_sext = 1'b1;
         end
         10'h00D: begin
            is_ri = 1'b1;
            ri_op = OP_AND;
         end
         10'h00E: begin
            is_ri = 1'b1;
            ri_op = OP_OR;
         end
         10'h00F: begin
            is_ri = 1'b1;
            ri_op = OP_XOR;
         end
         default: ;
      endcase
   end

   assign is_lu  = (op7 == 7'h0A);
   assign is_pca = (op7 == 7'h0E);

   // Logical immediates are zero-extended, arithmetic
   // and compare immediates sign-extended.
   assign imm12 = ri_sext
      ? {{20{inst[21]}}, inst[21:10]}
      : {20'd0, inst[21:10]};
   assign imm20 = {inst[24:5], 12'h000};

   always_comb begin
      dec         = '0;
      dec.rd      = inst[4:0];
      dec.pc      = pc;
      dec.alu_op  = OP_ADD;
      dec.illegal = 1'b0;
      unique case (1'b1)
         is_3r: begin
            dec.alu_op = inst[19:15];
            dec.src0   = rf_rdata1;
            dec.src1   = rf_rdata2;
         end
         is_shi: begin
            dec.alu_op = sh_op;
            dec.src0   = rf_rdata1;
            dec.src1   = {27'd0, inst[14:10]};
         end
         is_ri: begin
            dec.alu_op = ri_op;
            dec.src0   = rf_rdata1;
            dec.src1   = imm12;
         end
         is_lu: begin
            dec.alu_op = OP_SRC1;
            dec.src0   = 32'd0;
            dec.src1   = imm20;
         end
         is_pca: begin
            dec.alu_op = OP_ADD;
            dec.src0   = pc;
            dec.src1   = imm20;
         end
         default: dec.illegal = 1'b1;
      endcase
      dec.rf_we = !dec.illegal && (dec.rd != 5'd0);
   end

   assign in_ready = !vld || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign fire     = vld && out_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= 1'b0;
         q   <= '0;
         cnt <= 32'd0;
      end else begin
         if (flush)
            vld <= 1'b0;
         else if (accept)
            vld <= 1'b1;
         else if (out_ready)
            vld <= 1'b0;
         // Fields only move on accept, which also
         // keeps them frozen through a stall.
         if (accept)
            q <= dec;
         if (fire)
            cnt <= cnt + 32'd1;
      end
   end

   assign out_valid = vld;
   assign alu_op    = q.alu_op;
   assign alu_src0  = q.src0;
   assign alu_src1  = q.src1;
   assign rd        = q.rd;
   assign rf_we     = q.rf_we;
   assign pc_out    = q.pc;
   assign illegal   = q.illegal;
   assign issue_cnt = cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors against a
// behavioural model plus literal expectations.

module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] inst = 32'd0;
   logic [31:0] pc = 32'd0;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [4:0]  alu_op;
   logic [31:0] alu_src0;
   logic [31:0] alu_src1;
   logic [4:0]  rd;
   logic        rf_we;
   logic [31:0] pc_out;
   logic        illegal;
   logic [31:0] issue_cnt;

   logic [31:0] regs [32];
   logic [31:0] tv [10];

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic        ill;
      logic [4:0]  op;
      logic [31:0] s0;
      logic [31:0] s1;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] pc;
   } exp_t;

   logic        m_valid = 1'b0;
   exp_t        m_e = '0;
   logic [31:0] m_cnt = 32'd0;

   assign rf_rdata1 = regs[rf_raddr1];
   assign rf_rdata2 = regs[rf_raddr2];

   alu_issue_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inst      (inst),
      .pc        (pc),
      .rf_raddr1 (rf_raddr1),
      .rf_raddr2 (rf_raddr2),
      .rf_rdata1 (rf_rdata1),
      .rf_rdata2 (rf_rdata2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_op    (alu_op),
      .alu_src0  (alu_src0),
      .alu_src1  (alu_src1),
      .rd        (rd),
      .rf_we     (rf_we),
      .pc_out    (pc_out),
      .illegal   (illegal),
      .issue_cnt (issue_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h @%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Decode straight from the instruction tables.
   function automatic exp_t mdec(input logic [31:0] i,
                                 input logic [31:0] p);
      exp_t        e;
      logic [31:0] a;
      logic [31:0] b;
      logic [16:0] f17;
      logic [9:0]  f10;
      a   = regs[i[9:5]];
      b   = regs[i[14:10]];
      f17 = i[31:15];
      f10 = i[31:22];
      e   = '0;
      e.rd = i[4:0];
      e.pc = p;
      if (f17 inside {17'h20, 17'h22, 17'h24, 17'h25,
                      17'h29, 17'h2A, 17'h2B, 17'h2E,
                      17'h2F, 17'h30}) begin
         e.op = i[19:15];
         e.s0 = a;
         e.s1 = b;
      end else if (f17 inside {17'h81, 17'h89, 17'h91}) begin
         e.op = (f17 == 17'h81) ? 5'd14 :
                (f17 == 17'h89) ? 5'd15 : 5'd16;
         e.s0 = a;
         e.s1 = {27'd0, i[14:10]};
      end else if (f10 inside {10'h8, 10'h9, 10'hA}) begin
         e.op = (f10 == 10'hA) ? 5'd0 :
                (f10 == 10'h8) ? 5'd4 : 5'd5;
         e.s0 = a;
         e.s1 = {{20{i[21]}}, i[21:10]};
      end else if (f10 inside {10'hD, 10'hE, 10'hF}) begin
         e.op = (f10 == 10'hD) ? 5'd9 :
                (f10 == 10'hE) ? 5'd10 : 5'd11;
         e.s0 = a;
         e.s1 = {20'd0, i[21:10]};
      end else if (i[31:25] == 7'h0A) begin
         e.op = 5'd18;
         e.s1 = {i[24:5], 12'h000};
      end else if (i[31:25] == 7'h0E) begin
         e.op = 5'd0;
         e.s0 = p;
         e.s1 = {i[24:5], 12'h000};
      end else begin
         e.ill = 1'b1;
      end
      e.we = !e.ill && (e.rd != 5'd0);
      return e;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_e     <= '0;
         m_cnt   <= 32'd0;
      end else begin
         if (m_valid && out_ready && !flush)
            m_cnt <= m_cnt + 32'd1;
         if (flush)
            m_valid <= 1'b0;
         else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1'b1;
            m_e     <= mdec(inst, pc);
         end else if (out_ready)
            m_valid <= 1'b0;
      end
   end

   always @(negedge clk) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("in_ready", 32'(in_ready),
          32'(!m_valid || out_ready));
      chk("rf_raddr1", 32'(rf_raddr1), 32'(inst[9:5]));
      chk("rf_raddr2", 32'(rf_raddr2), 32'(inst[14:10]));
      chk("issue_cnt", issue_cnt, m_cnt);
      if (m_valid || rst) begin
         chk("alu_op", 32'(alu_op), 32'(m_e.op));
         chk("alu_src0", alu_src0, m_e.s0);
         chk("alu_src1", alu_src1, m_e.s1);
         chk("rd", 32'(rd), 32'(m_e.rd));
         chk("rf_we", 32'(rf_we), 32'(m_e.we));
         chk("pc_out", pc_out, m_e.pc);
         chk("illegal", 32'(illegal), 32'(m_e.ill));
      end
   end

   task automatic cyc(input logic v, input logic [31:0] i,
                      input logic [31:0] p, input logic f,
                      input logic r);
      in_valid  = v;
      inst      = i;
      pc        = p;
      flush     = f;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] e3(input logic [16:0] o,
                                      input logic [4:0] k,
                                      input logic [4:0] j,
                                      input logic [4:0] d);
      return {o, k, j, d};
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, " alu_op"}, 32'(alu_op), 32'd0);
      chk({tag, " src0"}, alu_src0, 32'd0);
      chk({tag, " src1"}, alu_src1, 32'd0);
      chk({tag, " rd"}, 32'(rd), 32'd0);
      chk({tag, " rf_we"}, 32'(rf_we), 32'd0);
      chk({tag, " pc_out"}, pc_out, 32'd0);
      chk({tag, " illegal"}, 32'(illegal), 32'd0);
      chk({tag, " issue_cnt"}, issue_cnt, 32'd0);
   endtask

   logic [31:0] sub8;

   initial begin
      for (int r = 0; r < 32; r++)
         regs[r] = 32'h1000_0000 + 32'(r) * 32'h111;
      regs[0] = 32'd0;
      regs[1] = 32'd5;
      regs[2] = 32'd7;
      regs[7] = 32'h8000_0010;

      tv[0] = e3(17'h25, 5'd1, 5'd7, 5'd9);
      tv[1] = e3(17'h2E, 5'd2, 5'd1, 5'd10);
      tv[2] = e3(17'h2B, 5'd2, 5'd7, 5'd11);
      tv[3] = {10'h008, 12'hFFB, 5'd7, 5'd12};
      tv[4] = {10'h00E, 12'hFFF, 5'd1, 5'd13};
      tv[5] = {17'h81, 5'd31, 5'd1, 5'd14};
      tv[6] = {7'h0E, 20'h80001, 5'd15};
      tv[7] = e3(17'h28, 5'd2, 5'd1, 5'd16);
      tv[8] = 32'hFFFF_FFFF;
      tv[9] = e3(17'h20, 5'd2, 5'd1, 5'd0);
      sub8  = e3(17'h22, 5'd2, 5'd1, 5'd8);

      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;
      chk("post-reset in_ready", 32'(in_ready), 32'd1);

      cyc(1'b1, 32'h0010_0823, 32'h0000_1000, 1'b0, 1'b1);
      chk("add valid", 32'(out_valid), 32'd1);
      chk("add op", 32'(alu_op), 32'd0);
      chk("add src0", alu_src0, 32'd5);
      chk("add src1", alu_src1, 32'd7);
      chk("add rd", 32'(rd), 32'd3);
      chk("add we", 32'(rf_we), 32'd1);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("add cnt", issue_cnt, 32'd1);
      chk("drain valid", 32'(out_valid), 32'd0);

      cyc(1'b1, 32'h02BF_FC24, 32'h0000_1004, 1'b0, 1'b1);
      chk("addi op", 32'(alu_op), 32'd0);
      chk("addi src1", alu_src1, 32'hFFFF_FFFF);
      chk("addi rd", 32'(rd), 32'd4);

      cyc(1'b1, 32'h1424_68A5, 32'h0000_1008, 1'b0, 1'b1);
      chk("lu12i op", 32'(alu_op), 32'h12);
      chk("lu12i src1", alu_src1, 32'h1234_5000);
      chk("lu12i src0", alu_src0, 32'd0);

      cyc(1'b1, 32'h0048_8CE6, 32'h0000_100C, 1'b0, 1'b1);
      chk("srai op", 32'(alu_op), 32'h10);
      chk("srai src1", alu_src1, 32'd3);
      chk("srai src0", alu_src0, 32'h8000_0010);
      chk("srai raddr1", 32'(rf_raddr1), 32'd7);
      chk("srai cnt", issue_cnt, 32'd3);

      for (int k = 0; k < 10; k++) begin
         cyc(1'b1, tv[k], 32'h3000 + 32'(k) * 32'd4,
             1'b0, 1'b1);
         if (k == 3)
            chk("slti src1", alu_src1, 32'hFFFF_FFFB);
         if (k == 4)
            chk("ori src1", alu_src1, 32'h0000_0FFF);
         if (k == 6) begin
            chk("pcadd src0", alu_src0, 32'h0000_3018);
            chk("pcadd src1", alu_src1, 32'h8000_1000);
         end
         if (k == 7)
            chk("nor illegal", 32'(illegal), 32'd1);
         if (k == 8) begin
            chk("ill illegal", 32'(illegal), 32'd1);
            chk("ill we", 32'(rf_we), 32'd0);
            chk("ill op", 32'(alu_op), 32'd0);
            chk("ill src0", alu_src0, 32'd0);
         end
         if (k == 9)
            chk("rd0 we", 32'(rf_we), 32'd0);
      end
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      chk("table cnt", issue_cnt, 32'd14);

      cyc(1'b1, sub8, 32'h0000_4000, 1'b0, 1'b0);
      for (int s = 0; s < 3; s++) begin
         cyc(1'b1, tv[0], 32'h0000_4004, 1'b0, 1'b0);
         chk("stall valid", 32'(out_valid), 32'd1);
         chk("stall op", 32'(alu_op), 32'd2);
         chk("stall src0", alu_src0, 32'd5);
         chk("stall rd", 32'(rd), 32'd8);
         chk("stall pc", pc_out, 32'h0000_4000);
         chk("stall in_ready", 32'(in_ready), 32'd0);
      end
      cyc(1'b1, tv[0], 32'h0000_4004, 1'b1, 1'b0);
      chk("flush valid", 32'(out_valid), 32'd0);
      chk("flush cnt", issue_cnt, 32'd14);

      cyc(1'b1, sub8, 32'h0000_5000, 1'b0, 1'b1);
      cyc(1'b1, tv[1], 32'h0000_5004, 1'b1, 1'b1);
      chk("flush2 valid", 32'(out_valid), 32'd0);
      chk("flush2 cnt", issue_cnt, 32'd14);

      cyc(1'b1, 32'h0010_0823, 32'h0000_6000, 1'b0, 1'b1);
      cyc(1'b1, 32'h1424_68A5, 32'h0000_6004, 1'b0, 1'b0);
      chk("pre-rst valid", 32'(out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk_zero("rst pulse");
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst in_ready", 32'(in_ready), 32'd1);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
